// File: rtl/life_pkg.sv
// Shared types, widths and LFSR helper for the Game-of-Life controller.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GRID_W = 64;
    localparam int GEN_W  = 16;

    // Feedback taps 64,63,61,60 expressed as bit positions 63,62,60,59.
    localparam logic [GRID_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    // One Fibonacci shift: new bit enters at the LSB.
    function automatic logic [GRID_W-1:0] lfsr_next(input logic [GRID_W-1:0] q);
        return {q[GRID_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

    // Generation counter increment that sticks at all-ones.
    function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
        logic [GEN_W-1:0] r;
        if (v == {GEN_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(GEN_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/life_controller_lfsr64.sv
// Free-running 64-bit Fibonacci LFSR used as the random grid source.
module lfsr64
    import life_pkg::*;
#(
    parameter logic [GRID_W-1:0] INIT = 64'h0412_6424_0034_3C28
) (
    input  logic              clk,
    input  logic              reset,
    output logic [GRID_W-1:0] q
);

    logic [GRID_W-1:0] q_r;

    // Shift every cycle; reset reloads the seed value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_r <= INIT;
        end else begin
            q_r <= lfsr_next(q_r);
        end
    end

    assign q = q_r;

endmodule

// File: rtl/life_controller.sv
// Sequencer for the 8x8 Game-of-Life: owns the grid, loads it from a seed
// or the LFSR, and advances it by single step or at a fixed tick rate,
// stopping once the pattern stops changing.
module life_controller
    import life_pkg::*;
#(
    parameter int                TICK_DIV  = 4,
    parameter logic [GRID_W-1:0] LFSR_INIT = 64'h0412_6424_0034_3C28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              randomize,
    input  logic              play,
    input  logic              step,
    input  logic [GRID_W-1:0] seed,
    input  logic [GRID_W-1:0] next_grid,
    output logic [GRID_W-1:0] grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic              running,
    output logic              stable,
    output logic              advance
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    state_t            state_r, state_nx;
    logic [GRID_W-1:0] grid_r, grid_nx;
    logic [GEN_W-1:0]  gen_r, gen_nx;
    logic [TICK_W-1:0] tick_r, tick_nx;
    logic              adv_r, adv_nx;
    logic              running_r, stable_r;
    logic              do_adv_s;
    logic [GRID_W-1:0] lfsr_q_s;

    lfsr64 #(.INIT(LFSR_INIT)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q_s)
    );

    // Next-state logic: loads first, then per-state play/step handling,
    // then the shared advance-or-halt decision.
    always_comb begin
        state_nx = state_r;
        grid_nx  = grid_r;
        gen_nx   = gen_r;
        tick_nx  = tick_r;
        adv_nx   = 1'b0;
        do_adv_s = 1'b0;

        if (start) begin
            grid_nx  = seed;
            gen_nx   = {GEN_W{1'b0}};
            tick_nx  = TICK_ZERO;
            state_nx = IDLE;
        end else if (randomize) begin
            grid_nx  = lfsr_q_s;
            gen_nx   = {GEN_W{1'b0}};
            tick_nx  = TICK_ZERO;
            state_nx = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (play) begin
                        state_nx = RUN;
                        tick_nx  = TICK_ZERO;
                    end else if (step) begin
                        do_adv_s = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                RUN: begin
                    if (!play) begin
                        state_nx = IDLE;
                        tick_nx  = TICK_ZERO;
                    end else if (tick_r == TICK_LAST) begin
                        do_adv_s = 1'b1;
                        tick_nx  = TICK_ZERO;
                    end else begin
                        tick_nx  = tick_r + TICK_ONE;
                    end
                end
                DONE: begin
                    state_nx = DONE;
                end
                default: begin
                    state_nx = IDLE;
                    tick_nx  = TICK_ZERO;
                end
            endcase

            // An unchanged successor means a still life: halt instead.
            if (do_adv_s) begin
                if (next_grid != grid_r) begin
                    grid_nx = next_grid;
                    gen_nx  = sat_inc(gen_r);
                    adv_nx  = 1'b1;
                end else begin
                    state_nx = DONE;
                end
            end else begin
                adv_nx = 1'b0;
            end
        end
    end

    // State and output registers; status flags follow the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            grid_r    <= {GRID_W{1'b0}};
            gen_r     <= {GEN_W{1'b0}};
            tick_r    <= TICK_ZERO;
            adv_r     <= 1'b0;
            running_r <= 1'b0;
            stable_r  <= 1'b0;
        end else begin
            state_r   <= state_nx;
            grid_r    <= grid_nx;
            gen_r     <= gen_nx;
            tick_r    <= tick_nx;
            adv_r     <= adv_nx;
            running_r <= (state_nx == RUN);
            stable_r  <= (state_nx == DONE);
        end
    end

    assign grid      = grid_r;
    assign gen_count = gen_r;
    assign running   = running_r;
    assign stable    = stable_r;
    assign advance   = adv_r;

endmodule

// File: tb/tb_life_controller.sv
// Self-checking bench for life_controller: directed scenarios plus random
// stimulus, all compared against a behavioural model of the controller.
module tb_life_controller;

    localparam int          TICK_DIV  = 4;
    localparam logic [63:0] LFSR_INIT = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] SEED0     = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] BLINK_H   = 64'h0000_0000_0038_0000;
    localparam logic [63:0] BLINK_V   = 64'h0000_0000_1010_1000;
    localparam logic [63:0] BLOCK     = 64'h0000_0000_0018_1800;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic        clk = 1'b0;
    logic        reset, start, randomize, play, step;
    logic [63:0] seed, next_grid, grid;
    logic [15:0] gen_count;
    logic        running, stable, advance;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_state;
    logic [63:0] m_grid;
    int          m_gen;
    int          m_tick;
    logic [63:0] m_lfsr;
    logic        m_adv;

    always #5 clk = ~clk;

    // Game-of-Life rule on a bounded 8x8 board (cells outside are dead).
    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        n = 64'd0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                            (c + dc) >= 0 && (c + dc) < 8) begin
                            cnt += int'(g[8 * (r + dr) + (c + dc)]);
                        end
                    end
                end
                n[8 * r + c] = (cnt == 3) || (cnt == 2 && g[8 * r + c]);
            end
        end
        return n;
    endfunction

    assign next_grid = life_next(grid);

    life_controller #(.TICK_DIV(TICK_DIV), .LFSR_INIT(LFSR_INIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .randomize (randomize),
        .play      (play),
        .step      (step),
        .seed      (seed),
        .next_grid (next_grid),
        .grid      (grid),
        .gen_count (gen_count),
        .running   (running),
        .stable    (stable),
        .advance   (advance)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // LFSR with taps 64,63,61,60 (bits 63,62,60,59), shifting left.
    function automatic logic [63:0] ref_lfsr(input logic [63:0] v);
        logic fb;
        fb = v[63] ^ v[62] ^ v[60] ^ v[59];
        return {v[62:0], fb};
    endfunction

    task automatic model_try_advance();
        logic [63:0] nx;
        nx = life_next(m_grid);
        if (nx == m_grid) begin
            m_state = M_DONE;
        end else begin
            m_grid = nx;
            m_gen  = (m_gen >= 65535) ? 65535 : m_gen + 1;
            m_adv  = 1'b1;
        end
    endtask

    // Behavioural update for one rising edge using the current inputs.
    task automatic model_edge();
        logic [63:0] cur;
        m_adv = 1'b0;
        if (!reset) begin
            m_state = M_IDLE; m_grid = 64'd0; m_gen = 0; m_tick = 0; m_lfsr = LFSR_INIT;
        end else begin
            cur    = m_lfsr;
            m_lfsr = ref_lfsr(m_lfsr);
            if (start || randomize) begin
                m_grid  = start ? seed : cur;
                m_gen   = 0;
                m_tick  = 0;
                m_state = M_IDLE;
            end else if (m_state == M_IDLE) begin
                if (play) begin
                    m_state = M_RUN;
                    m_tick  = 0;
                end else if (step) begin
                    model_try_advance();
                end
            end else if (m_state == M_RUN) begin
                if (!play) begin
                    m_state = M_IDLE;
                    m_tick  = 0;
                end else begin
                    m_tick++;
                    if (m_tick == TICK_DIV) begin
                        m_tick = 0;
                        model_try_advance();
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("grid",    grid,             m_grid);
        check_val("gen",     64'(gen_count),   64'(m_gen));
        check_val("running", 64'(running),     64'(m_state == M_RUN));
        check_val("stable",  64'(stable),      64'(m_state == M_DONE));
        check_val("advance", 64'(advance),     64'(m_adv));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        start = 1'b0; randomize = 1'b0; play = 1'b0; step = 1'b0;
    endtask

    initial begin
        reset = 1'b0; idle_inputs(); seed = 64'd0;
        m_state = M_IDLE; m_grid = 64'd0; m_gen = 0; m_tick = 0; m_lfsr = LFSR_INIT; m_adv = 1'b0;
        @(negedge clk);
        cycle(); cycle();
        check_val("rst_grid",    grid,              64'd0);
        check_val("rst_gen",     64'(gen_count),    64'd0);
        check_val("rst_running", 64'(running),      64'd0);
        check_val("rst_stable",  64'(stable),       64'd0);
        check_val("rst_advance", 64'(advance),      64'd0);
        reset = 1'b1;

        // Empty board is a still life.
        step = 1'b1; cycle(); step = 1'b0;
        check_val("empty_step_stable", 64'(stable), 64'd1);

        // Seed load.
        seed = SEED0; start = 1'b1; cycle(); start = 1'b0;
        check_val("load_grid",   grid,           SEED0);
        check_val("load_gen",    64'(gen_count), 64'd0);
        check_val("load_stable", 64'(stable),    64'd0);
        check_val("load_adv",    64'(advance),   64'd0);

        // Blinker single steps.
        seed = BLINK_H; start = 1'b1; cycle(); start = 1'b0;
        step = 1'b1; cycle(); step = 1'b0;
        check_val("blink1_grid", grid,           BLINK_V);
        check_val("blink1_gen",  64'(gen_count), 64'd1);
        check_val("blink1_adv",  64'(advance),   64'd1);
        cycle();
        check_val("blink1_adv_drop", 64'(advance), 64'd0);
        step = 1'b1; cycle(); step = 1'b0;
        check_val("blink2_grid", grid,           BLINK_H);
        check_val("blink2_gen",  64'(gen_count), 64'd2);

        // Free-run: advances land every TICK_DIV edges after play.
        seed = BLINK_H; start = 1'b1; cycle(); start = 1'b0;
        play = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            cycle();
            check_val($sformatf("run_adv_%0d", i), 64'(advance), 64'(i > 0 && i % 4 == 0));
            if (i > 0 && i % 4 == 0) begin
                check_val($sformatf("run_gen_%0d", i), 64'(gen_count), 64'(i / 4));
            end
        end
        play = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_val("pause_adv", 64'(advance), 64'd0);
        end
        check_val("pause_running", 64'(running),   64'd0);
        check_val("pause_gen",     64'(gen_count), 64'd3);

        // Block halts at the first tick.
        seed = BLOCK; start = 1'b1; cycle(); start = 1'b0;
        play = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_val("block_no_adv", 64'(advance), 64'd0);
        end
        check_val("block_stable", 64'(stable),    64'd1);
        check_val("block_gen",    64'(gen_count), 64'd0);
        step = 1'b1; cycle(); cycle(); step = 1'b0; play = 1'b0; cycle();
        check_val("done_hold_grid",   grid,        BLOCK);
        check_val("done_hold_stable", 64'(stable), 64'd1);
        randomize = 1'b1;
        begin
            logic [63:0] expect_lfsr;
            expect_lfsr = m_lfsr;
            cycle();
            check_val("rand_grid", grid, expect_lfsr);
        end
        randomize = 1'b0;
        check_val("rand_stable", 64'(stable), 64'd0);

        // start beats randomize.
        seed = BLINK_V; start = 1'b1; randomize = 1'b1; cycle(); idle_inputs();
        check_val("prio_grid", grid, BLINK_V);

        // Reset in the middle of free-run at gen_count 5.
        play = 1'b1;
        for (int i = 0; i < 200 && gen_count != 16'd5; i++) cycle();
        check_val("midrun_gen5", 64'(gen_count), 64'd5);
        reset = 1'b0; cycle(); reset = 1'b1; play = 1'b0;
        check_val("midrst_grid",    grid,            64'd0);
        check_val("midrst_gen",     64'(gen_count),  64'd0);
        check_val("midrst_running", 64'(running),    64'd0);
        randomize = 1'b1; cycle(); randomize = 1'b0;
        check_val("midrst_lfsr", grid, LFSR_INIT);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) != 0);
            start     = ($urandom_range(0, 39) == 0);
            randomize = ($urandom_range(0, 39) == 0);
            step      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) play = ~play;
            case ($urandom_range(0, 2))
                0:       seed = BLINK_H;
                1:       seed = {$urandom, $urandom} & {$urandom, $urandom};
                default: seed = {$urandom, $urandom};
            endcase
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
